hier_path_decoder: RTL and testbench
====================================

# hier_path_decoder

Streaming decoder that turns a per-level child-index path, one digit per level, into a flat leaf number for the generated module hierarchy. Each digit is the child index at one hierarchy level: level 0 is the root and the last digit is the leaf. Digits are combined in mixed-radix form by the Horner rule. The block is the inverse of hierarchy path naming: test infrastructure uses it to map a traced instance path back to a linear leaf ID for coverage and lookup tables.

## Interface
- DEPTH, 10, maximum number of path levels (digits) per path
- FANOUT, 5, children per node; every legal digit is in 0..FANOUT-1
- DIG_W, 4, in_digit width; must satisfy 2^DIG_W >= FANOUT
- LEAF_W, 24, out_leaf width; must satisfy 2^LEAF_W >= FANOUT^DEPTH
- clk  in  1  single clock; all logic is rising-edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  in_digit/in_last are valid
- in_ready  out  1  block accepts a digit this cycle
- in_digit  in  DIG_W  child index at the current level
- in_last  in  1  this digit terminates the path
- out_valid  out  1  decoded result available
- out_ready  in  1  consumer takes the result
- out_leaf  out  LEAF_W  accumulated mixed-radix leaf number
- out_depth  out  $clog2(DEPTH+1)  number of digits consumed (1..DEPTH)
- out_err  out  1  path contained an illegal digit (see Configuration)

## Operation
- The block has three states:
  - IDLE: no digits held.
  - COLLECT: at least one digit accepted, path not yet terminated.
  - HOLD: result presented on the outputs.
- A digit is accepted when in_valid && in_ready.
- in_ready = 1 in IDLE and COLLECT, 0 in HOLD.
- Accumulation on each accepted digit:
  - acc <= acc*FANOUT + in_digit, computed at LEAF_W bits (the mandatory LEAF_W parameter rule prevents overflow).
  - An accept in IDLE uses acc = 0 as the start value.
  - cnt is incremented on every accepted digit.
  - err latches (OR) the range flag from Configuration.
- Termination: an accepted digit with in_last=1, or the DEPTH-th accepted digit, moves the block to HOLD. In HOLD, out_leaf=acc, out_depth=cnt and out_err=err.
- At DEPTH digits without in_last, the path still terminates; in_last is ignored for the length count.
- IDLE -> COLLECT on an accepted non-terminating digit.
- IDLE -> HOLD on an accepted terminating digit, i.e. a single-digit path.
- HOLD -> IDLE on out_ready. acc, cnt and err are cleared at the same time.
- An early in_last gives a partial path. out_depth then reports the shorter length, and out_leaf is the Horner sum over the digits received.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 from the first cycle after reset deassertion. out_valid=0, out_leaf=0, out_depth=0, out_err=0.
- Latency: out_valid rises on the clock edge that accepts the terminating digit, so the result is visible in the following cycle.
- Throughput: one digit per cycle. There is at least one bubble between paths, because in_ready=0 for every HOLD cycle.
- out_leaf, out_depth and out_err are stable while out_valid=1 && out_ready=0.
- out_valid is cleared on the edge where out_valid && out_ready. in_ready returns to 1 in the next cycle; there is no same-cycle bypass.
- in_valid while in_ready=0 is not accepted, and the digit is not lost: the source must hold it.
- rst_n=0 mid-path or in HOLD returns the block to IDLE at the next edge and discards any partial result.
- out_ready while out_valid=0 has no effect.

## Configuration
- HPD_RANGE_CHECK_EN defined:
  - Any accepted digit >= FANOUT sets err.
  - The digit is still accumulated as given.
  - out_err reports err for that path.
- HPD_RANGE_CHECK_EN undefined:
  - No comparator is built and out_err is tied to 0.
  - Behaviour with illegal digits is undefined but deterministic: raw Horner arithmetic, truncated to LEAF_W.

## Test plan
- Reset check: assert rst_n=0 for 2 cycles, then release. Required: in_ready=0 during reset; in_ready=1 from the first cycle after release; out_valid=0, out_leaf=0, out_depth=0, out_err=0.
- Full path, defaults: feed digits 0,0,0,0,0,0,1,2,1,3 with in_last only on the 10th digit. Required: out_leaf=183 and out_depth=10 one cycle later; out_err=0.
- Auto-termination: feed 10 digits, each 4, with in_last=0 throughout. Required: HOLD after the 10th digit, out_leaf=9765624, out_depth=10.
- Partial path with backpressure: feed 2,3 with in_last on the 3; hold out_ready=0 for 5 cycles. Required: out_leaf=13 and out_depth=2, stable for all 5 cycles; in_ready=0 throughout; in_ready=1 the cycle after out_ready is raised.
- Range error, with HPD_RANGE_CHECK_EN: feed 1,7 with in_last. Required: out_err=1, out_leaf=12.
- Range error, without HPD_RANGE_CHECK_EN: same stimulus. Required: out_err=0, out_leaf=12.
- Reset mid-path: feed 3 digits, pulse rst_n low for one cycle, then feed path 4 with in_last. Required: out_leaf=4, out_depth=1; no stale state from the aborted path.

Source files
------------

// File: rtl/hier_path_decoder.sv
// hier_path_decoder
//
// Streaming mixed-radix decoder. It accepts one child-index digit per cycle,
// with the root level first, and folds the digits into a flat leaf number by
// the Horner rule: acc = acc * FANOUT + digit. A path ends on a digit with
// in_last_i set, or on the DEPTH-th digit. The result is then held on the
// outputs until the consumer takes it.
//
// Optional feature: define HPD_RANGE_CHECK_EN to flag digits >= FANOUT on
// out_err_o. When the macro is undefined, no comparator is built and out_err_o
// is tied low.
//
// Ports
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   in_valid_i   in_digit_i / in_last_i are valid
//   in_ready_o   block accepts a digit this cycle (low while a result is held)
//   in_digit_i   child index at the current level
//   in_last_i    this digit terminates the path
//   out_valid_o  decoded result available
//   out_ready_i  consumer takes the result
//   out_leaf_o   accumulated mixed-radix leaf number
//   out_depth_o  number of digits consumed (1..DEPTH)
//   out_err_o    path contained a digit >= FANOUT (range check builds only)
module hier_path_decoder #(
  parameter int unsigned DEPTH  = 10,
  parameter int unsigned FANOUT = 5,
  parameter int unsigned DIG_W  = 4,
  parameter int unsigned LEAF_W = 24
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DIG_W-1:0]           in_digit_i,
  input  logic                       in_last_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [LEAF_W-1:0]          out_leaf_o,
  output logic [$clog2(DEPTH+1)-1:0] out_depth_o,
  output logic                       out_err_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [LEAF_W-1:0] FanoutL = LEAF_W'(FANOUT);
  localparam logic [CntW-1:0]   DepthL  = CntW'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StHold
  } state_e;

  state_e              state_q;
  logic [LEAF_W-1:0]   acc_q;
  logic [CntW-1:0]     cnt_q;
  logic                err_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic [LEAF_W-1:0]   out_leaf_q;
  logic [CntW-1:0]     out_depth_q;
  logic                out_err_q;

  logic                accept;
  logic                range_err;
  logic [LEAF_W-1:0]   acc_base;
  logic [LEAF_W-1:0]   acc_d;
  logic [CntW-1:0]     cnt_d;
  logic                err_d;
  logic                term;

`ifdef HPD_RANGE_CHECK_EN
  // Widen before comparing so FANOUT == 2^DIG_W cannot wrap the constant.
  assign range_err = (32'(in_digit_i) >= FANOUT);
`else
  assign range_err = 1'b0;
`endif

  assign accept = in_valid_i && in_ready_q;

  // Next-state accumulation for the digit on the input this cycle. A digit
  // accepted in StIdle starts a new path, so the held state is ignored there.
  always_comb begin
    acc_base = '0;
    cnt_d    = '0;
    err_d    = 1'b0;
    if (state_q == StCollect) begin
      acc_base = acc_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
    end
    acc_d = (acc_base * FanoutL) + LEAF_W'(in_digit_i);
    cnt_d = cnt_d + CntW'(1);
    err_d = err_d | range_err;
    term  = in_last_i || (cnt_d == DepthL);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_leaf_q  <= '0;
      out_depth_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StCollect: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (term) begin
              state_q     <= StHold;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_leaf_q  <= acc_d;
              out_depth_q <= cnt_d;
              out_err_q   <= err_d;
            end else begin
              state_q <= StCollect;
            end
          end
        end
        StHold: begin
          // Outputs stay frozen until the consumer takes them.
          if (out_ready_i) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_leaf_q  <= '0;
            out_depth_q <= '0;
            out_err_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_leaf_o  = out_leaf_q;
  assign out_depth_o = out_depth_q;
  assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_hier_path_decoder.sv
// Directed testbench for hier_path_decoder with hand-computed expectations.
module tb_hier_path_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_digit;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_leaf;
  logic [3:0]  out_depth;
  logic        out_err;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  hier_path_decoder dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_digit_i  (in_digit),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_leaf_o  (out_leaf),
    .out_depth_o (out_depth),
    .out_err_o   (out_err)
  );

  // Present one digit and hold it until accepted (bounded wait).
  task automatic send(input logic [3:0] d, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_digit = d;
    in_last  = last;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      vecs++; errs++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    vecs++;
    if (out_valid !== 1'b0) begin
      errs++; $display("FAIL release_valid: got %0b required 0", out_valid);
    end
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL release_ready: got %0b required 1", in_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (in_ready !== 1'b0) begin
        errs++; $display("FAIL reset_in_ready: got %0b required 0", in_ready);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL reset_release_ready: got %0b required 1", in_ready);
    end
    vecs++;
    if ({out_valid, out_leaf, out_depth, out_err} !== 30'd0) begin
      errs++;
      $display("FAIL reset_outputs: got v=%0b leaf=%0d depth=%0d err=%0b required all 0",
               out_valid, out_leaf, out_depth, out_err);
    end
  endtask

  task automatic test_full_path();
    logic [3:0] digs [10];
    digs = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd1, 4'd3};
    for (int i = 0; i < 10; i++) send(digs[i], i == 9);
    vecs++;
    if (out_valid !== 1'b1 || out_leaf !== 24'd183 || out_depth !== 4'd10 || out_err !== 1'b0) begin
      errs++;
      $display("FAIL full_path: got v=%0b leaf=%0d depth=%0d err=%0b required v=1 leaf=183 depth=10 err=0",
               out_valid, out_leaf, out_depth, out_err);
    end
    release_result();
  endtask

  task automatic test_auto_term();
    for (int i = 0; i < 10; i++) send(4'd4, 1'b0);
    vecs++;
    if (out_valid !== 1'b1 || out_leaf !== 24'd9765624 || out_depth !== 4'd10) begin
      errs++;
      $display("FAIL auto_term: got v=%0b leaf=%0d depth=%0d required v=1 leaf=9765624 depth=10",
               out_valid, out_leaf, out_depth);
    end
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL auto_term_hold_ready: got %0b required 0", in_ready);
    end
    release_result();
  endtask

  task automatic test_backpressure();
    send(4'd2, 1'b0);
    send(4'd3, 1'b1);
    // A pending digit offered during HOLD must wait, not vanish.
    in_valid = 1'b1;
    in_digit = 4'd4;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vecs++;
      if (out_valid !== 1'b1 || out_leaf !== 24'd13 || out_depth !== 4'd2 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL backpressure_hold[%0d]: got v=%0b leaf=%0d depth=%0d rdy=%0b required v=1 leaf=13 depth=2 rdy=0",
                 i, out_valid, out_leaf, out_depth, in_ready);
      end
      @(posedge clk); #1;
    end
    release_result();
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    vecs++;
    if (out_valid !== 1'b1 || out_leaf !== 24'd4 || out_depth !== 4'd1) begin
      errs++;
      $display("FAIL held_digit: got v=%0b leaf=%0d depth=%0d required v=1 leaf=4 depth=1",
               out_valid, out_leaf, out_depth);
    end
    release_result();
  endtask

  task automatic test_range();
    logic exp_err;
`ifdef HPD_RANGE_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    send(4'd1, 1'b0);
    send(4'd7, 1'b1);
    vecs++;
    if (out_valid !== 1'b1 || out_leaf !== 24'd12 || out_depth !== 4'd2 || out_err !== exp_err) begin
      errs++;
      $display("FAIL range: got v=%0b leaf=%0d depth=%0d err=%0b required v=1 leaf=12 depth=2 err=%0b",
               out_valid, out_leaf, out_depth, out_err, exp_err);
    end
    release_result();
    // Error flag must not leak into the next legal path.
    send(4'd0, 1'b1);
    vecs++;
    if (out_err !== 1'b0 || out_leaf !== 24'd0 || out_depth !== 4'd1) begin
      errs++;
      $display("FAIL range_clear: got leaf=%0d depth=%0d err=%0b required leaf=0 depth=1 err=0",
               out_leaf, out_depth, out_err);
    end
    release_result();
  endtask

  task automatic test_reset_midpath();
    send(4'd1, 1'b0);
    send(4'd2, 1'b0);
    send(4'd3, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vecs++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errs++;
      $display("FAIL midreset_state: got rdy=%0b v=%0b required rdy=0 v=0", in_ready, out_valid);
    end
    send(4'd4, 1'b1);
    vecs++;
    if (out_valid !== 1'b1 || out_leaf !== 24'd4 || out_depth !== 4'd1 || out_err !== 1'b0) begin
      errs++;
      $display("FAIL midreset_path: got v=%0b leaf=%0d depth=%0d err=%0b required v=1 leaf=4 depth=1 err=0",
               out_valid, out_leaf, out_depth, out_err);
    end
    release_result();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_digit  = 4'd0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_full_path();
    test_auto_term();
    test_backpressure();
    test_range();
    test_reset_midpath();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
